// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// The FSM state encoding and the wait-counter width helper live here.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } mem_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Counter must hold the larger wait count; a zero-wait build still needs one bit.
  function automatic int cnt_width(input int read_wait, input int write_wait);
    int max_wait;
    int w;
    max_wait = (read_wait > write_wait) ? read_wait : write_wait;
    w = $clog2(max_wait + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter with a zero flag, used to time the SRAM strobe windows.
// Load wins over decrement; decrement saturates at zero.
module mem_wait_cnt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR interface: sequences async SRAM
// strobes with fixed wait states and returns read data with a one-cycle Ready.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              MEM_EN,
  input  logic              R_W,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] MDR_in,
  output logic [DATA_W-1:0] Mem_data_out,
  output logic              Ready,
  output logic              Busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam int               CNT_W    = cnt_width(READ_WAIT, WRITE_WAIT);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_WAIT);

  mem_state_t        state;
  mem_state_t        state_next;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              accept;
  logic              capture;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  mem_wait_cnt #(
    .WIDTH(CNT_W)
  ) u_wait_cnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = RD_LOAD;
    cnt_dec    = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (MEM_EN) begin
          accept = 1'b1;
          if (R_W == MEM_READ) begin
            cnt_load   = 1'b1;
            cnt_val    = RD_LOAD;
            state_next = ST_RD;
          end else begin
            state_next = ST_WR_SETUP;
          end
        end
      end
      ST_RD: begin
        if (cnt_zero) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        cnt_load   = 1'b1;
        cnt_val    = WR_LOAD;
        state_next = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          state_next = ST_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_HOLD: state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; later CPU-side changes are ignored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= MAR;
      wdata_q <= MDR_in;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Mem_data_out <= '0;
    end else if (capture) begin
      Mem_data_out <= SRAM_DQ_in;
    end
  end

  // Strobes are decoded from the state register only, so reset clears them at once.
  always_comb begin
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_DQ_oe = 1'b0;
    Ready      = 1'b0;
    Busy       = (state != ST_IDLE);
    unique case (state)
      ST_RD: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        SRAM_CE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
      end
      ST_WR_PULSE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
        SRAM_WE_N  = 1'b0;
      end
      ST_DONE: Ready = 1'b1;
      default: ;
    endcase
  end

  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_out = wdata_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the LC-3 datapath; the other end of the MAR/MDR memory interface.
- Accepts a read or write request from the CPU control FSM (MEM_EN, R_W, MAR, MDR_in).
- Sequences the asynchronous SRAM strobes with fixed wait states.
- Returns read data (to the MDR input select path) with a one-cycle Ready pulse.

Parameters:
ADDR_W, 16, address width to SRAM
DATA_W, 16, data word width
READ_WAIT, 2, extra cycles OE_N is held low before read capture (0 legal)
WRITE_WAIT, 2, extra cycles WE_N is held low beyond one (0 legal)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  reset, asynchronous, active-low
MEM_EN  in  1  request strobe from CPU FSM (level)
R_W  in  1  0 = read, 1 = write
MAR  in  ADDR_W  request address
MDR_in  in  DATA_W  write data
Mem_data_out  out  DATA_W  last read word, registered
Ready  out  1  one-cycle completion pulse
Busy  out  1  high whenever state is not IDLE
SRAM_ADDR  out  ADDR_W  latched address
SRAM_DQ_out  out  DATA_W  write data to pad
SRAM_DQ_oe  out  1  pad output enable
SRAM_DQ_in  in  DATA_W  read data from pad
SRAM_CE_N  out  1  chip enable, active-low
SRAM_OE_N  out  1  output enable, active-low
SRAM_WE_N  out  1  write enable, active-low

Behaviour:
- Reset (Reset_n=0, asynchronous, any state):
  - state=IDLE, cnt=0, addr/wdata/Mem_data_out=0.
  - Ready=0, Busy=0, CE_N=OE_N=WE_N=1, DQ_oe=0.
- Outputs: all SRAM and handshake outputs are Moore-decoded from registered state; no combinational path from inputs to outputs.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - Strobes all high; DQ_oe=0.
  - MEM_EN=1 at an edge: latch MAR, MDR_in, R_W.
  - Read: load cnt=READ_WAIT, go to RD. Write: go to WR_SETUP.
- RD:
  - CE_N=0, OE_N=0.
  - Each edge: if cnt==0, capture SRAM_DQ_in into Mem_data_out and go to DONE; else cnt--.
  - RD lasts READ_WAIT+1 cycles.
- WR_SETUP:
  - 1 cycle: CE_N=0, DQ_oe=1, WE_N=1.
  - Load cnt=WRITE_WAIT, go to WR_PULSE.
- WR_PULSE:
  - CE_N=0, DQ_oe=1, WE_N=0.
  - Lasts WRITE_WAIT+1 cycles (same counting as RD), then go to WR_HOLD.
- WR_HOLD: 1 cycle: CE_N=0, DQ_oe=1, WE_N=1; then DONE.
- DONE: 1 cycle, Ready=1, no strobes; unconditionally go to IDLE.
- Latency (accept edge E0):
  - Read: capture at E(READ_WAIT+1); Ready high in the following cycle.
  - Write: Ready high in the cycle after E(WRITE_WAIT+3).
- SRAM_ADDR / SRAM_DQ_out: driven from latched registers, stable for the whole transaction.
- Boundary conditions:
  - MAR, MDR_in, R_W and MEM_EN changes after acceptance are ignored. No abort; the transaction completes and Ready still pulses.
  - Requests are accepted only in IDLE. MEM_EN held high through DONE does not re-trigger; it is re-evaluated at the first IDLE edge.
  - Back-to-back requests: minimum gap is the DONE cycle.
  - Writes never modify Mem_data_out.
  - Reset mid-write deasserts WE_N immediately, with no Ready.

Decomposition:
- Package mem_pkg:
  - mem_state_t enum (six states).
  - Constants MEM_READ=1'b0, MEM_WRITE=1'b1.
- One sub-module, mem_wait_cnt: loadable down-counter with a zero flag, width $clog2(max(READ_WAIT,WRITE_WAIT)+1), minimum 1.

Test Plan:
- Reset: assert Reset_n=0 mid-RD -> same-cycle CE_N=OE_N=WE_N=1, DQ_oe=0, Ready=0, Mem_data_out=0x0000, Busy=0.
- Read, READ_WAIT=2, MAR=0x3000, model holds 0xBEEF -> SRAM_ADDR=0x3000, OE_N low exactly 3 cycles, Mem_data_out=0xBEEF, Ready high exactly 1 cycle, 4th cycle after accept.
- Write, WRITE_WAIT=2, MAR=0x1234, MDR_in=0x5A5A -> DQ_oe=1 for 5 cycles, WE_N low exactly 3 cycles inside them, DQ_out=0x5A5A throughout, Mem_data_out unchanged, single Ready.
- Perturbation: after read accept at 0x3000, drive MAR=0xFFFF and MEM_EN=0 -> SRAM_ADDR stays 0x3000, Ready still pulses once.
- Back-to-back: write 0x00C3 to 0x0040, hold MEM_EN through DONE, then read 0x0040 -> read returns 0x00C3, exactly two Ready pulses, no spurious third transaction.
- READ_WAIT=0, WRITE_WAIT=0 build: read -> OE_N low 1 cycle, Ready in 2nd cycle; reset during WR_PULSE -> WE_N high immediately, following read completes normally.
